// File: rtl/comp_thresh_dac_ser_pkg.sv
// Shared types and constants for the comparator-threshold DAC serialiser.
package comp_thresh_dac_ser_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned THRESH_W = 12;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned EXP_BITS = 16;

  localparam logic [CMD_W-1:0] CMD_WR_UPD = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Everything that is triplicated; voted bitwise as one vector.
  typedef struct packed {
    state_t              state;
    logic [FRAME_W-1:0]  sreg;
    logic [CNT_W-1:0]    cnt;
    logic [THRESH_W-1:0] pend;
    logic                pend_v;
    logic                start;
    logic                err;
  } tmr_regs_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [THRESH_W-1:0] th);
    return {CMD_WR_UPD, th};
  endfunction

endpackage

// File: rtl/comp_thresh_dac_ser_if.sv
// Sequencer/threshold handshake and DAC serial pins of the serialiser.
interface comp_thresh_dac_ser_if;
  import comp_thresh_dac_ser_pkg::*;

  logic                LOAD_REQ;
  logic [THRESH_W-1:0] THRESH;
  logic                SHFT_ENA;
  logic                SET_DONE;
  logic                START;
  logic                DAC_DIN;
  logic                DAC_CS_N;
  logic                BUSY;
  logic                DONE;
  logic                ERR;

  modport slave (
    input  LOAD_REQ, THRESH, SHFT_ENA, SET_DONE,
    output START, DAC_DIN, DAC_CS_N, BUSY, DONE, ERR
  );

  modport master (
    output LOAD_REQ, THRESH, SHFT_ENA, SET_DONE,
    input  START, DAC_DIN, DAC_CS_N, BUSY, DONE, ERR
  );

endinterface

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/comp_thresh_dac_ser.sv
// Comparator-threshold DAC serialiser: frames a threshold with the write-and-update
// command and shifts it out MSB first under the external load sequencer. TMR state.
module comp_thresh_dac_ser
  import comp_thresh_dac_ser_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  comp_thresh_dac_ser_if.slave sif
);

  localparam int unsigned REGS_W = $bits(tmr_regs_t);

  tmr_regs_t         r_cp0, r_cp1, r_cp2;
  tmr_regs_t         w_v;
  tmr_regs_t         w_nxt;
  logic [REGS_W-1:0] w_vote;
  logic              r_done;
  logic              w_done_nxt;

  tmr_vote #(.WIDTH(REGS_W)) u_vote (
    .i_a (REGS_W'(r_cp0)),
    .i_b (REGS_W'(r_cp1)),
    .i_c (REGS_W'(r_cp2)),
    .o_y (w_vote)
  );

  assign w_v = tmr_regs_t'(w_vote);

  function automatic tmr_regs_t shift_one(input tmr_regs_t r);
    tmr_regs_t s;
    s      = r;
    s.sreg = {r.sreg[FRAME_W-2:0], 1'b0};
    s.cnt  = (r.cnt == {CNT_W{1'b1}}) ? r.cnt : r.cnt + CNT_W'(1);
    return s;
  endfunction

  function automatic tmr_regs_t launch(input tmr_regs_t r, input logic [THRESH_W-1:0] th);
    tmr_regs_t s;
    s       = r;
    s.state = ST_LOAD;
    s.sreg  = make_frame(th);
    s.cnt   = '0;
    s.start = 1'b1;
    return s;
  endfunction

  // Next state for every triplicated copy, computed from the voted value.
  always_comb begin
    w_nxt      = w_v;
    w_done_nxt = 1'b0;
    case (w_v.state)
      ST_IDLE: begin
        if (w_v.pend_v) begin
          w_nxt        = launch(w_v, w_v.pend);
          w_nxt.pend_v = sif.LOAD_REQ;
          if (sif.LOAD_REQ) w_nxt.pend = sif.THRESH;
        end else if (sif.LOAD_REQ) begin
          w_nxt = launch(w_v, sif.THRESH);
        end
        if (sif.SHFT_ENA) w_nxt.err = 1'b1;
      end
      ST_LOAD: begin
        w_nxt.start = 1'b1;
        if (sif.SHFT_ENA) begin
          w_nxt       = shift_one(w_v);
          w_nxt.state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sif.SET_DONE) begin
          w_nxt.state = ST_RELEASE;
          w_nxt.start = 1'b0;
          w_done_nxt  = 1'b1;
          if (w_v.cnt != CNT_W'(EXP_BITS)) w_nxt.err = 1'b1;
        end else if (sif.SHFT_ENA) begin
          w_nxt = shift_one(w_v);
        end
      end
      ST_RELEASE: begin
        w_nxt.start = 1'b0;
        if (sif.SHFT_ENA)  w_nxt.err   = 1'b1;
        if (!sif.SET_DONE) w_nxt.state = ST_IDLE;
      end
      default: w_nxt.state = ST_IDLE;
    endcase
    // A request arriving mid-frame parks in the one-deep pending slot, last write wins.
    if ((w_v.state != ST_IDLE) && sif.LOAD_REQ) begin
      w_nxt.pend   = sif.THRESH;
      w_nxt.pend_v = 1'b1;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_cp0  <= '0;
      r_cp1  <= '0;
      r_cp2  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cp0  <= w_nxt;
      r_cp1  <= w_nxt;
      r_cp2  <= w_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign sif.START    = w_v.start;
  assign sif.BUSY     = (w_v.state != ST_IDLE);
  assign sif.DONE     = r_done;
  assign sif.ERR      = w_v.err;
  assign sif.DAC_DIN  = w_v.sreg[FRAME_W-1];
  assign sif.DAC_CS_N = ((w_v.state == ST_LOAD) || (w_v.state == ST_SHIFT)) ? ~sif.SHFT_ENA : 1'b1;

endmodule
